// File: rtl/sm83_irq_dispatch_if.sv
// Signal bundle between the SM83 decoder/datapath (master) and the interrupt
// dispatch sequencer (slave).
interface sm83_irq_dispatch_if #(
  parameter int NUM_IRQ = 5
);
  logic               mcyc_en;
  logic               instr_boundary;
  logic               ctl_ei;
  logic               ctl_di;
  logic               ctl_reti;
  logic               ctl_halt;
  logic [NUM_IRQ-1:0] irq_src;
  logic               if_wr;
  logic               ie_wr;
  logic [7:0]         reg_wdata;
  logic [7:0]         if_q;
  logic [7:0]         ie_q;
  logic               ime_q;
  logic               halt_q;
  logic               disp_busy;
  logic               disp_sp_dec;
  logic               disp_mem_wr;
  logic               disp_wsel_msb;
  logic               disp_pc_load;
  logic [15:0]        disp_vector;

  modport master (
    output mcyc_en, instr_boundary, ctl_ei, ctl_di, ctl_reti, ctl_halt,
           irq_src, if_wr, ie_wr, reg_wdata,
    input  if_q, ie_q, ime_q, halt_q, disp_busy, disp_sp_dec, disp_mem_wr,
           disp_wsel_msb, disp_pc_load, disp_vector
  );

  modport slave (
    input  mcyc_en, instr_boundary, ctl_ei, ctl_di, ctl_reti, ctl_halt,
           irq_src, if_wr, ie_wr, reg_wdata,
    output if_q, ie_q, ime_q, halt_q, disp_busy, disp_sp_dec, disp_mem_wr,
           disp_wsel_msb, disp_pc_load, disp_vector
  );
endinterface

// File: rtl/sm83_irq_dispatch.sv
// SM83 interrupt controller: IF/IE/IME, EI delay, HALT wake-up and the
// 5 M-cycle dispatch sequence that pushes PC and jumps to the vector.
module sm83_irq_dispatch #(
  parameter int          NUM_IRQ  = 5,
  parameter logic [15:0] VEC_BASE = 16'h0040
) (
  input logic                clk,
  input logic                rst_n,
  sm83_irq_dispatch_if.slave bus
);

  localparam int SEL_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [2:0] {IDLE, D1, D2, D3, D4, D5} state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] if_flags;
  logic [7:0]         ie_mask;
  logic               ime;
  logic               ei_pend;
  logic               halt;
  logic               busy;
  logic               sp_dec;
  logic               mem_wr;
  logic               wsel_msb;
  logic               pc_load;
  logic [15:0]        vector;

  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] if_next;
  logic [SEL_W-1:0]   sel;
  logic               any_pending;
  logic               start;

  // Lowest pending bit wins; the IF clear of a dispatch yields to a same-clk request.
  always_comb begin
    pending     = ie_mask[NUM_IRQ-1:0] & if_flags;
    any_pending = |pending;
    sel         = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) sel = SEL_W'(i);
    end
    start   = (state == IDLE) && ime && any_pending && (bus.instr_boundary || halt);
    if_next = bus.if_wr ? bus.reg_wdata[NUM_IRQ-1:0] : if_flags;
    if (bus.mcyc_en && (state == D4) && any_pending) if_next[sel] = 1'b0;
    if_next = if_next | bus.irq_src;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_flags <= '0;
      ie_mask  <= 8'h00;
    end else begin
      if_flags <= if_next;
      if (bus.ie_wr) ie_mask <= bus.reg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ime      <= 1'b0;
      ei_pend  <= 1'b0;
      halt     <= 1'b0;
      busy     <= 1'b0;
      sp_dec   <= 1'b0;
      mem_wr   <= 1'b0;
      wsel_msb <= 1'b0;
      pc_load  <= 1'b0;
      vector   <= 16'h0000;
    end else if (bus.mcyc_en) begin
      sp_dec   <= 1'b0;
      mem_wr   <= 1'b0;
      wsel_msb <= 1'b0;
      pc_load  <= 1'b0;

      // A pending request always wakes the core, even with IME clear.
      if (any_pending) halt <= 1'b0;
      else if (bus.ctl_halt && (state == IDLE)) halt <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state   <= D1;
            busy    <= 1'b1;
            ime     <= 1'b0;
            ei_pend <= 1'b0;
          end else if (bus.ctl_di) begin
            ime     <= 1'b0;
            ei_pend <= 1'b0;
          end else begin
            if (bus.ctl_reti || (ei_pend && bus.instr_boundary)) ime <= 1'b1;
            if (bus.ctl_ei) ei_pend <= 1'b1;
            else if (ei_pend && bus.instr_boundary) ei_pend <= 1'b0;
          end
        end
        D1: begin
          state  <= D2;
          sp_dec <= 1'b1;
        end
        D2: begin
          state    <= D3;
          sp_dec   <= 1'b1;
          mem_wr   <= 1'b1;
          wsel_msb <= 1'b1;
        end
        D3: begin
          state  <= D4;
          mem_wr <= 1'b1;
        end
        D4: begin
          // Pending is re-read here so an IE write done by the high-byte push can cancel the jump.
          state   <= D5;
          pc_load <= 1'b1;
          vector  <= any_pending ? (VEC_BASE + (16'(sel) << 3)) : 16'h0000;
        end
        D5: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.if_q          = {{(8 - NUM_IRQ){1'b1}}, if_flags};
  assign bus.ie_q          = ie_mask;
  assign bus.ime_q         = ime;
  assign bus.halt_q        = halt;
  assign bus.disp_busy     = busy;
  assign bus.disp_sp_dec   = sp_dec;
  assign bus.disp_mem_wr   = mem_wr;
  assign bus.disp_wsel_msb = wsel_msb;
  assign bus.disp_pc_load  = pc_load;
  assign bus.disp_vector   = vector;

endmodule
